add_subt_arbiter: RTL

- Controller and round-robin arbiter that shares one registered Add_Subt datapath between two requesters, A and B.
- Accepts each operation with a req/grant handshake and latches the operands.
- Sequences the datapath load strobe and waits the datapath latency.
- Returns the registered result, carry/overflow and zero flags with a done pulse to the requester that owns the operation.
- Sits between the FPU front-end sequencers and the Add_Subt stage.

---
 rtl/add_subt_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/add_subt_arbiter.sv
// add_subt_arbiter
// Shares one registered Add_Subt datapath between two requesters (A and B).
// A round-robin arbiter grants one operation at a time. The grant edge latches
// the operation and operands. The controller then pulses the datapath load
// strobe, waits out the datapath latency, and registers the result and flags.
// A one-cycle done pulse goes to the requester that owns the operation.
//
// Ports
//   clk, rst                   : rising-edge clock, asynchronous active-low reset
//   req_x_i, op_x_i            : request level and operation (0 add, 1 subtract)
//   opa_x_i, opb_x_i           : operands, captured on the grant edge
//   gnt_x_o                    : one-cycle grant
//   done_x_o                   : one-cycle completion pulse to the owner
//   result_o, ovf_o, zero_o    : registered result/flags of the last completed op
//   busy_o                     : high whenever the controller is not idle
//   load_o, add_sub_op_o,
//   data_a_o, data_b_o         : datapath control and operands
//   data_result_i, fsm_c_i     : datapath result and carry/overflow
module add_subt_arbiter #(
    parameter int SWR = 26,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_a_i,
    input  logic           op_a_i,
    input  logic [SWR-1:0] opa_a_i,
    input  logic [SWR-1:0] opb_a_i,
    input  logic           req_b_i,
    input  logic           op_b_i,
    input  logic [SWR-1:0] opa_b_i,
    input  logic [SWR-1:0] opb_b_i,
    output logic           gnt_a_o,
    output logic           gnt_b_o,
    output logic           done_a_o,
    output logic           done_b_o,
    output logic [SWR-1:0] result_o,
    output logic           ovf_o,
    output logic           zero_o,
    output logic           busy_o,
    output logic           load_o,
    output logic           add_sub_op_o,
    output logic [SWR-1:0] data_a_o,
    output logic [SWR-1:0] data_b_o,
    input  logic [SWR-1:0] data_result_i,
    input  logic           fsm_c_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t         state_reg, state_next;
    logic [3:0]     cnt_reg;
    logic           owner_reg;     // 0 = A, 1 = B
    logic           last_srv_reg;  // 0 = A, 1 = B
    logic           op_reg;
    logic [SWR-1:0] opa_reg, opb_reg;
    logic [SWR-1:0] result_reg;
    logic           ovf_reg;
    logic           zero_reg;

    logic arb_en;
    logic grant;
    logic pick_b;
    logic capture;

    // Arbitration is only open in IDLE and RESP. RESP is included so that
    // back-to-back operations issue without an idle bubble.
    always_comb begin
        arb_en = (state_reg == IDLE) || (state_reg == RESP);
        pick_b = req_b_i && (!req_a_i || !last_srv_reg);
        grant  = arb_en && (req_a_i || req_b_i);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (grant) state_next = ISSUE;
            ISSUE: state_next = (LAT == 1) ? RESP : WAIT;
            WAIT:  if (cnt_reg == 4'd1) state_next = RESP;
            RESP:  state_next = grant ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The result is captured on the edge that enters RESP. It is therefore
    // valid in the same cycle as the done pulse.
    assign capture = (state_next == RESP) && (state_reg != RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            owner_reg    <= 1'b0;
            last_srv_reg <= 1'b1;
            op_reg       <= 1'b0;
            opa_reg      <= '0;
            opb_reg      <= '0;
            result_reg   <= '0;
            ovf_reg      <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                op_reg       <= pick_b ? op_b_i  : op_a_i;
                opa_reg      <= pick_b ? opa_b_i : opa_a_i;
                opb_reg      <= pick_b ? opb_b_i : opb_a_i;
                owner_reg    <= pick_b;
                last_srv_reg <= pick_b;
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= LAT_M1;
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (capture) begin
                result_reg <= data_result_i;
                ovf_reg    <= fsm_c_i;
                zero_reg   <= (data_result_i == '0);
            end
        end
    end

    // The grants are gated with rst. This keeps every output at 0 while
    // reset is asserted, even if a request is already pending.
    assign gnt_a_o      = grant && !pick_b && rst;
    assign gnt_b_o      = grant && pick_b && rst;
    assign done_a_o     = (state_reg == RESP) && !owner_reg;
    assign done_b_o     = (state_reg == RESP) && owner_reg;
    assign load_o       = (state_reg == ISSUE);
    assign busy_o       = (state_reg != IDLE);
    assign result_o     = result_reg;
    assign ovf_o        = ovf_reg;
    assign zero_o       = zero_reg;
    assign add_sub_op_o = op_reg;
    assign data_a_o     = opa_reg;
    assign data_b_o     = opb_reg;

endmodule
